vga_term_writer: RTL and testbench
==================================

Name: vga_term_writer

Overview:
- Terminal write engine upstream of the character buffer.
- Accepts ASCII keycodes over a valid/ready handshake and maintains the cursor position.
- Emits single-cell buffer writes using the {h[6:0], v[4:0]} address format.
- Manages line_offset for page scrolling, clearing each newly entered row.
- Its cursor and offset outputs feed the VGA read-address and cursor-blink logic.

Parameters:
- COLS, 70: visible characters per line.
- ROWS, 30: visible lines. Physical buffer rows = 2^V_W = 32.
- H_W, 7: column index width.
- V_W, 5: row index width.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- key_valid  input  1  key_data is valid this cycle.
- key_data  input  8  ASCII code.
- key_ready  output  1  block can accept a key. High only in IDLE.
- wr_en  output  1  one-cycle buffer write strobe.
- wr_addr  output  12  {column[6:0], physical_row[4:0]}.
- wr_data  output  8  byte to write.
- cur_h  output  7  cursor column, 0..COLS-1.
- cur_v  output  5  cursor visible row, 0..ROWS-1.
- line_offset  output  5  physical row of visible row 0.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: key_ready=0 for exactly one cycle, then 1 in IDLE. wr_en=0, wr_addr=0, wr_data=0x20, cur_h=0, cur_v=0, line_offset=0, state=IDLE.
- Physical row = (cur_v + line_offset) mod 32. The 5-bit addition wraps naturally.
- Handshake: a key is accepted when key_valid && key_ready. key_data is sampled only on acceptance.
- States: IDLE, PUT, CLEAR.
- Printable key (0x20..0x7E): IDLE->PUT.
  - In PUT, wr_en=1 for one cycle with addr {cur_h, phys(cur_v)} and data = the key.
  - If cur_h < COLS-1: cur_h++ and return to IDLE.
  - Otherwise: perform a newline (below).
- Newline (0x0D or 0x0A, or wrap at COLS-1):
  - cur_h=0.
  - If cur_v < ROWS-1: cur_v++.
  - Else: cur_v stays ROWS-1 and line_offset++ (scroll).
  - The updates above take effect on the same edge. Then enter CLEAR.
- CLEAR: writes 0x20 to columns 0..COLS-1 of the new physical row, one per cycle (70 cycles, wr_en high throughout), then returns to IDLE.
  - A newline from IDLE takes 1 + 70 cycles until key_ready.
  - A wrap takes PUT (1) + CLEAR (70).
- Backspace (0x08):
  - If cur_h > 0: cur_h--, then PUT writes 0x20 at the new position without advancing the cursor.
  - If cur_h = 0 and cur_v > 0: cur_h = COLS-1, cur_v--, then write 0x20 there.
  - At (0,0): no write, return to IDLE next cycle. line_offset never decrements.
- Other codes (0x00..0x1F except 0x08/0x0A/0x0D, and 0x7F..0xFF): accepted and ignored. Return to IDLE after one cycle with no write.
- Keys presented while key_ready=0 are held by the producer. Nothing is dropped.
- line_offset wraps 31->0.
- Reset mid-CLEAR or mid-PUT: abort immediately with no further writes, and all outputs take their reset values on the next edge.
- wr_en, wr_addr and wr_data are registered outputs.

Optional Feature:
- Macro: VGA_TERM_CLEAR_ON_RESET_EN.
- Defined: after reset, enter INIT state. It writes 0x20 to all 70x32 physical cells in address order: column outer 0..69, row inner 0..31, 2240 cycles. key_ready=0 throughout; then IDLE.
- Undefined: no INIT state. IDLE follows reset directly, and buffer contents are undefined until written.

Decomposition:
- Package vga_term_pkg holds:
  - ASCII constants: ASC_SPACE=8'h20, ASC_BS=8'h08, ASC_LF=8'h0A, ASC_CR=8'h0D.
  - state enum term_state_t {IDLE, PUT, CLEAR, INIT}.
  - COLS/ROWS defaults.
- No sub-module. The row-clear counter and cursor logic live in one FSM module.

Test Plan:
- Reset then key 0x41 -> one wr_en pulse with addr {7'd0,5'd0}, data 0x41; cur_h=1; key_ready back high 2 cycles after acceptance.
- Send 70 × 0x42 from (0,0):
  - Last write at addr {7'd69,5'd0}.
  - Then exactly 70 writes of 0x20 to row 1.
  - Cursor ends at (0,1).
- Send 30 × 0x0D from (0,0) -> cur_v=29, line_offset=1. The last CLEAR writes 0x20 to physical row 30 (29+1).
- Send 35 newlines, then backspace at (0,29):
  - cur_h=69, cur_v=28.
  - 0x20 written at {7'd69, phys row (28+6)=2}.
- Key 0x01 and backspace at (0,0) -> no wr_en, state returns to IDLE, cursor unchanged.
- Assert rst in cycle 10 of a CLEAR -> wr_en=0 next cycle, all outputs at reset values. With VGA_TERM_CLEAR_ON_RESET_EN defined: key_ready low for 2240 cycles, 2240 writes of 0x20.

Source files
------------

// File: rtl/vga_term_pkg.sv
// Shared constants, state encoding and key-classification helpers for the terminal write engine.
package vga_term_pkg;

    localparam int COLS_DEF = 70;
    localparam int ROWS_DEF = 30;
    localparam int H_W_DEF  = 7;
    localparam int V_W_DEF  = 5;

    localparam logic [7:0] ASC_SPACE = 8'h20;
    localparam logic [7:0] ASC_BS    = 8'h08;
    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_CR    = 8'h0D;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PUT   = 2'd1,
        CLEAR = 2'd2,
        INIT  = 2'd3
    } term_state_t;

    function automatic logic is_printable(input logic [7:0] k);
        return (k >= 8'h20) && (k <= 8'h7E);
    endfunction

    function automatic logic is_newline(input logic [7:0] k);
        return (k == ASC_CR) || (k == ASC_LF);
    endfunction

endpackage

// File: rtl/vga_term_writer.sv
// Terminal write engine: keycodes in, single-cell character-buffer writes out, cursor and scroll tracking.
// Optional VGA_TERM_CLEAR_ON_RESET_EN blanks the whole buffer after reset before accepting keys.
module vga_term_writer
    import vga_term_pkg::*;
#(
    parameter int COLS = COLS_DEF,
    parameter int ROWS = ROWS_DEF,
    parameter int H_W  = H_W_DEF,
    parameter int V_W  = V_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_valid,
    input  logic [7:0]         key_data,
    output logic               key_ready,
    output logic               wr_en,
    output logic [H_W+V_W-1:0] wr_addr,
    output logic [7:0]         wr_data,
    output logic [H_W-1:0]     cur_h,
    output logic [V_W-1:0]     cur_v,
    output logic [V_W-1:0]     line_offset
);

    localparam logic [H_W-1:0] LAST_COL = H_W'(COLS - 1);
    localparam logic [V_W-1:0] LAST_ROW = V_W'(ROWS - 1);

    term_state_t          state_q, state_d;
    logic                 key_ready_q, key_ready_d;
    logic                 wr_en_q, wr_en_d;
    logic [H_W+V_W-1:0]   wr_addr_q, wr_addr_d;
    logic [7:0]           wr_data_q, wr_data_d;
    logic [H_W-1:0]       cur_h_q, cur_h_d;
    logic [V_W-1:0]       cur_v_q, cur_v_d;
    logic [V_W-1:0]       line_offset_q, line_offset_d;
    logic [7:0]           key_q, key_d;
    logic                 do_wr_q, do_wr_d;
    logic [H_W-1:0]       clr_q, clr_d;
    logic [V_W-1:0]       phys_row;
`ifdef VGA_TERM_CLEAR_ON_RESET_EN
    logic [V_W-1:0]       init_row_q, init_row_d;
`endif

    // Modulo-2^V_W wrap of the physical row is intentional.
    assign phys_row = cur_v_q + line_offset_q;

    always_comb begin
        state_d       = state_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        cur_h_d       = cur_h_q;
        cur_v_d       = cur_v_q;
        line_offset_d = line_offset_q;
        key_d         = key_q;
        do_wr_d       = do_wr_q;
        clr_d         = clr_q;
`ifdef VGA_TERM_CLEAR_ON_RESET_EN
        init_row_d    = init_row_q;
`endif
        case (state_q)
            IDLE: begin
                if (key_valid && key_ready_q) begin
                    key_d   = key_data;
                    state_d = PUT;
                    do_wr_d = is_printable(key_data);
                    // Backspace moves the cursor now so PUT blanks the cell it lands on.
                    if (key_data == ASC_BS) begin
                        if (cur_h_q != '0) begin
                            cur_h_d = cur_h_q - H_W'(1);
                            do_wr_d = 1'b1;
                        end else if (cur_v_q != '0) begin
                            cur_h_d = LAST_COL;
                            cur_v_d = cur_v_q - V_W'(1);
                            do_wr_d = 1'b1;
                        end
                    end
                end
            end
            PUT: begin
                if (do_wr_q) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = {cur_h_q, phys_row};
                    wr_data_d = is_printable(key_q) ? key_q : ASC_SPACE;
                end
                state_d = IDLE;
                if ((is_printable(key_q) && (cur_h_q == LAST_COL)) || is_newline(key_q)) begin
                    cur_h_d = '0;
                    if (cur_v_q < LAST_ROW) cur_v_d = cur_v_q + V_W'(1);
                    else                    line_offset_d = line_offset_q + V_W'(1);
                    clr_d   = '0;
                    state_d = CLEAR;
                end else if (is_printable(key_q)) begin
                    cur_h_d = cur_h_q + H_W'(1);
                end
            end
            CLEAR: begin
                wr_en_d   = 1'b1;
                wr_addr_d = {clr_q, phys_row};
                wr_data_d = ASC_SPACE;
                if (clr_q == LAST_COL) state_d = IDLE;
                else                   clr_d   = clr_q + H_W'(1);
            end
            INIT: begin
`ifdef VGA_TERM_CLEAR_ON_RESET_EN
                // clr_q doubles as the column counter; rows sweep fastest.
                wr_en_d    = 1'b1;
                wr_addr_d  = {clr_q, init_row_q};
                wr_data_d  = ASC_SPACE;
                init_row_d = init_row_q + V_W'(1);
                if (init_row_q == {V_W{1'b1}}) begin
                    if (clr_q == LAST_COL) state_d = IDLE;
                    else                   clr_d   = clr_q + H_W'(1);
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
        key_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef VGA_TERM_CLEAR_ON_RESET_EN
            state_q    <= INIT;
            init_row_q <= '0;
`else
            state_q    <= IDLE;
`endif
            key_ready_q   <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= ASC_SPACE;
            cur_h_q       <= '0;
            cur_v_q       <= '0;
            line_offset_q <= '0;
            key_q         <= '0;
            do_wr_q       <= 1'b0;
            clr_q         <= '0;
        end else begin
`ifdef VGA_TERM_CLEAR_ON_RESET_EN
            init_row_q <= init_row_d;
`endif
            state_q       <= state_d;
            key_ready_q   <= key_ready_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            cur_h_q       <= cur_h_d;
            cur_v_q       <= cur_v_d;
            line_offset_q <= line_offset_d;
            key_q         <= key_d;
            do_wr_q       <= do_wr_d;
            clr_q         <= clr_d;
        end
    end

    assign key_ready   = key_ready_q;
    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign cur_h       = cur_h_q;
    assign cur_v       = cur_v_q;
    assign line_offset = line_offset_q;

endmodule

// File: tb/tb_vga_term_writer.sv
// Bench for vga_term_writer: directed scenarios plus random keys against a cursor/scroll reference model.
module tb_vga_term_writer;

    localparam int COLS = 70;
    localparam int ROWS = 30;

    logic        clk;
    logic        rst;
    logic        key_valid;
    logic [7:0]  key_data;
    logic        key_ready;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic [6:0]  cur_h;
    logic [4:0]  cur_v;
    logic [4:0]  line_offset;

    int n_checks = 0;
    int n_errors = 0;
    logic sb_on = 1'b0;
    logic [19:0] exp_q[$];
    int mh, mv, moff;

    vga_term_writer dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_data(key_data),
        .key_ready(key_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cur_h(cur_h), .cur_v(cur_v), .line_offset(line_offset)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // scoreboard: every buffer write must match the front of the expected queue
    always @(negedge clk) begin
        if (sb_on && wr_en) begin
            if (exp_q.size() == 0) chk("wr_extra", {12'h0, wr_addr, wr_data}, 32'hFFFF_FFFF);
            else                   chk("wr", {12'h0, wr_addr, wr_data}, {12'h0, exp_q.pop_front()});
        end
    end

    // reference model
    function automatic void push_wr(input int c, input int r, input logic [7:0] d);
        logic [19:0] e;
        e = {7'(c), 5'(r % 32), d};
        exp_q.push_back(e);
    endfunction

    function automatic void model_newline();
        mh = 0;
        if (mv < ROWS - 1) mv++;
        else moff = (moff + 1) % 32;
        for (int c = 0; c < COLS; c++) push_wr(c, mv + moff, 8'h20);
    endfunction

    function automatic int model_key(input logic [7:0] k);
        if (k >= 8'h20 && k <= 8'h7E) begin
            push_wr(mh, mv + moff, k);
            if (mh < COLS - 1) begin
                mh++;
                return 1;
            end
            model_newline();
            return 71;
        end
        if (k == 8'h0D || k == 8'h0A) begin
            model_newline();
            return 71;
        end
        if (k == 8'h08) begin
            if (mh > 0) begin
                mh--;
                push_wr(mh, mv + moff, 8'h20);
            end else if (mv > 0) begin
                mh = COLS - 1;
                mv--;
                push_wr(mh, mv + moff, 8'h20);
            end
        end
        return 1;
    endfunction

    // driver tasks
    task automatic reset_dut();
        int lows;
        int exp_lows;
        sb_on = 1'b0;
        rst = 1'b1;
        key_valid = 1'b0;
        @(posedge clk);
        @(negedge clk); #1;
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", 32'(wr_data), 32'h20);
        chk("rst_cur_h", 32'(cur_h), 0);
        chk("rst_cur_v", 32'(cur_v), 0);
        chk("rst_offset", 32'(line_offset), 0);
        chk("rst_ready", 32'(key_ready), 0);
        rst = 1'b0;
        mh = 0; mv = 0; moff = 0;
        exp_q.delete();
`ifdef VGA_TERM_CLEAR_ON_RESET_EN
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < 32; r++) push_wr(c, r, 8'h20);
        exp_lows = COLS * 32;
`else
        exp_lows = 1;
`endif
        sb_on = 1'b1;
        lows = 0;
        while (!key_ready && lows < 3000) begin
            lows++;
            @(negedge clk); #1;
        end
        chk("rst_ready_lat", 32'(lows), 32'(exp_lows));
        @(negedge clk); #1;
        chk("rst_pending", 32'(exp_q.size()), 0);
    endtask

    task automatic send_key(input logic [7:0] k, input int gap);
        int lows;
        int exp_lat;
        repeat (gap) begin
            @(negedge clk); #1;
        end
        exp_lat = model_key(k);
        key_valid = 1'b1;
        key_data = k;
        @(posedge clk);
        @(negedge clk); #1;
        key_valid = 1'b0;
        key_data = $urandom_range(0, 255);
        lows = 0;
        while (!key_ready && lows < 5000) begin
            lows++;
            @(negedge clk); #1;
        end
        chk($sformatf("lat_%02h", k), 32'(lows), 32'(exp_lat));
        chk("cur_h", 32'(cur_h), 32'(mh));
        chk("cur_v", 32'(cur_v), 32'(mv));
        chk("offset", 32'(line_offset), 32'(moff));
        @(negedge clk); #1;
        chk("pending", 32'(exp_q.size()), 0);
    endtask

    function automatic logic [7:0] rand_key();
        int r;
        logic [7:0] k;
        r = $urandom_range(0, 99);
        if (r < 60)      k = 8'($urandom_range(32, 126));
        else if (r < 65) k = 8'h0D;
        else if (r < 70) k = 8'h0A;
        else if (r < 85) k = 8'h08;
        else begin
            k = 8'($urandom_range(0, 31));
            if (k == 8'h08 || k == 8'h0A || k == 8'h0D) k = 8'($urandom_range(127, 255));
        end
        return k;
    endfunction

    initial begin
        rst = 1'b1;
        key_valid = 1'b0;
        key_data = 8'h00;
        @(negedge clk); #1;

        // single printable key
        reset_dut();
        send_key(8'h41, 0);

        // full line of 'B' wraps and clears row 1
        reset_dut();
        for (int i = 0; i < COLS; i++) send_key(8'h42, 0);

        // 30 carriage returns scroll once
        reset_dut();
        for (int i = 0; i < 30; i++) send_key(8'h0D, 0);

        // 35 newlines then backspace across a row boundary
        reset_dut();
        for (int i = 0; i < 35; i++) send_key((i % 2) ? 8'h0A : 8'h0D, 0);
        send_key(8'h08, 1);

        // ignored code and backspace at home
        reset_dut();
        send_key(8'h01, 0);
        send_key(8'h08, 2);
        send_key(8'hFF, 0);

        // enough newlines to wrap line_offset past 31
        reset_dut();
        for (int i = 0; i < 70; i++) send_key(8'h0A, 0);
        send_key(8'h5A, 0);

        // random key stream
        reset_dut();
        for (int i = 0; i < 300; i++) send_key(rand_key(), $urandom_range(0, 2));

        // reset in the middle of a CLEAR
        sb_on = 1'b0;
        key_valid = 1'b1;
        key_data = 8'h0D;
        @(posedge clk);
        @(negedge clk); #1;
        key_valid = 1'b0;
        repeat (10) begin
            @(negedge clk); #1;
        end
        chk("clear_active", 32'(wr_en), 1);
        reset_dut();
        send_key(8'h43, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
